// File: rtl/segment_transition_ctl.sv
// Per-segment playback index and segment-switch controller.
// Tracks index/loop/stop for the active segment and applies switches under SYNC_IDX, SYS_TIME, GPIO or EXT modes.
module segment_transition_ctl #(
  parameter int NUM_SEGMENT = 2,
  parameter int IDX_WIDTH   = 15,
  parameter int REP_WIDTH   = 16,
  parameter int NUM_GPIO    = 4,
  parameter int TIME_WIDTH  = 56,
  localparam int SEG_W      = (NUM_SEGMENT > 1) ? $clog2(NUM_SEGMENT) : 1
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             UPDATE_SETTINGS,
  input  logic [SEG_W-1:0]                 REQ_SEGMENT,
  input  logic [7:0]                       TRANSITION_MODE,
  input  logic [63:0]                      TRANSITION_VALUE,
  input  logic [NUM_SEGMENT*IDX_WIDTH-1:0] CYCLE,
  input  logic [NUM_SEGMENT*REP_WIDTH-1:0] REP,
  input  logic                             IDX_TICK,
  input  logic [TIME_WIDTH-1:0]            SYS_TIME,
  input  logic [NUM_GPIO-1:0]              GPIO_IN,
  output logic [SEG_W-1:0]                 SEGMENT,
  output logic [IDX_WIDTH-1:0]             IDX,
  output logic                             STOP,
  output logic                             PENDING
);

  localparam int GSEL_W = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;

  localparam logic [7:0] MODE_SYS_TIME = 8'h01;
  localparam logic [7:0] MODE_GPIO     = 8'h02;
  localparam logic [7:0] MODE_EXT      = 8'hF0;

  localparam logic [SEG_W:0]   SEG_COUNT = (SEG_W + 1)'(NUM_SEGMENT);
  localparam logic [SEG_W-1:0] SEG_LAST  = SEG_W'(NUM_SEGMENT - 1);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_WAIT_SYNC,
    ST_WAIT_TIME,
    ST_WAIT_GPIO,
    ST_EXT
  } state_t;

  state_t                state_q, state_d;
  logic [SEG_W-1:0]      segment_q, segment_d, req_q, req_d, req_clamped, seg_next;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d, cur_cyc, adv_idx;
  logic [REP_WIDTH-1:0]  loop_q, loop_d, cur_rep, adv_loop;
  logic                  stop_q, stop_d, pending_q, pending_d;
  logic                  adv_stop, stop_event, at_end, last_loop;
  logic                  time_reached, gpio_rise, apply_now;
  logic                  edge_q, edge_d;
  logic [IDX_WIDTH-1:0]  cycle_q [NUM_SEGMENT];
  logic [REP_WIDTH-1:0]  rep_q   [NUM_SEGMENT];
  logic [TIME_WIDTH-1:0] time_val_q;
  logic [GSEL_W-1:0]     pin_sel_q;
  logic [NUM_GPIO-1:0]   gpio_meta, gpio_sync, gpio_prev;
  logic                  unused_value;

  assign unused_value = ^TRANSITION_VALUE[63:TIME_WIDTH];

  always_comb begin
    cur_cyc      = cycle_q[segment_q];
    cur_rep      = rep_q[segment_q];
    at_end       = (idx_q >= cur_cyc);
    last_loop    = (cur_rep != '1) && (loop_q == cur_rep);
    time_reached = (SYS_TIME >= time_val_q);
    gpio_rise    = gpio_sync[pin_sel_q] & ~gpio_prev[pin_sel_q];
    seg_next     = (segment_q == SEG_LAST) ? '0 : segment_q + SEG_W'(1);
    req_clamped  = ({1'b0, REQ_SEGMENT} >= SEG_COUNT) ? SEG_LAST : REQ_SEGMENT;

    // Plain playback step; the final wrap freezes IDX at CYCLE instead of returning to 0
    adv_idx    = idx_q;
    adv_loop   = loop_q;
    adv_stop   = stop_q;
    stop_event = 1'b0;
    if (!stop_q) begin
      if (at_end) begin
        if (last_loop) begin
          adv_idx    = cur_cyc;
          adv_stop   = 1'b1;
          stop_event = 1'b1;
        end else begin
          adv_idx  = '0;
          adv_loop = loop_q + REP_WIDTH'(1);
        end
      end else begin
        adv_idx = idx_q + IDX_WIDTH'(1);
      end
    end

    state_d   = state_q;
    segment_d = segment_q;
    idx_d     = idx_q;
    loop_d    = loop_q;
    stop_d    = stop_q;
    pending_d = pending_q;
    req_d     = req_q;
    edge_d    = edge_q | ((state_q == ST_WAIT_GPIO) & gpio_rise);

    case (state_q)
      ST_WAIT_SYNC: apply_now = at_end | stop_q;
      ST_WAIT_TIME: apply_now = time_reached;
      ST_WAIT_GPIO: apply_now = edge_q;
      default:      apply_now = 1'b0;
    endcase

    if (IDX_TICK) begin
      if (apply_now) begin
        segment_d = req_q;
        idx_d     = '0;
        loop_d    = '0;
        stop_d    = 1'b0;
        pending_d = 1'b0;
        edge_d    = 1'b0;
        state_d   = ST_RUN;
      end else if ((state_q == ST_EXT) && (stop_event || stop_q)) begin
        segment_d = seg_next;
        idx_d     = '0;
        loop_d    = '0;
        stop_d    = 1'b0;
      end else begin
        idx_d  = adv_idx;
        loop_d = adv_loop;
        stop_d = adv_stop;
      end
    end

    // A new request overrides any armed one; a coincident tick has already used the old settings
    if (UPDATE_SETTINGS) begin
      req_d  = req_clamped;
      edge_d = 1'b0;
      if (TRANSITION_MODE == MODE_EXT) begin
        state_d   = ST_EXT;
        pending_d = 1'b0;
      end else if (req_clamped == segment_d) begin
        state_d   = ST_RUN;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
        case (TRANSITION_MODE)
          MODE_SYS_TIME: state_d = ST_WAIT_TIME;
          MODE_GPIO:     state_d = ST_WAIT_GPIO;
          default:       state_d = ST_WAIT_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_RUN;
      segment_q  <= '0;
      idx_q      <= '0;
      loop_q     <= '0;
      stop_q     <= 1'b0;
      pending_q  <= 1'b0;
      req_q      <= '0;
      edge_q     <= 1'b0;
      time_val_q <= '0;
      pin_sel_q  <= '0;
      gpio_meta  <= '0;
      gpio_sync  <= '0;
      gpio_prev  <= '0;
      for (int unsigned k = 0; k < NUM_SEGMENT; k++) begin
        cycle_q[k] <= '0;
        rep_q[k]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      segment_q <= segment_d;
      idx_q     <= idx_d;
      loop_q    <= loop_d;
      stop_q    <= stop_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      edge_q    <= edge_d;
      gpio_meta <= GPIO_IN;
      gpio_sync <= gpio_meta;
      gpio_prev <= gpio_sync;
      if (UPDATE_SETTINGS) begin
        time_val_q <= TRANSITION_VALUE[TIME_WIDTH-1:0];
        pin_sel_q  <= TRANSITION_VALUE[GSEL_W-1:0];
        for (int unsigned k = 0; k < NUM_SEGMENT; k++) begin
          cycle_q[k] <= CYCLE[k*IDX_WIDTH +: IDX_WIDTH];
          rep_q[k]   <= REP[k*REP_WIDTH +: REP_WIDTH];
        end
      end
    end
  end

  assign SEGMENT = segment_q;
  assign IDX     = idx_q;
  assign STOP    = stop_q;
  assign PENDING = pending_q;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Self-checking bench for segment_transition_ctl: vector table through a scoreboard queue,
// plus a hand-written EXT auto-advance and asynchronous-reset sequence.
module tb_segment_transition_ctl;

  localparam int NSEG = 4;
  localparam int IW   = 15;
  localparam int RW   = 16;
  localparam int NG   = 4;
  localparam int TW   = 56;

  logic                 CLK = 1'b0;
  logic                 RST_N = 1'b0;
  logic                 UPDATE_SETTINGS = 1'b0;
  logic [1:0]           REQ_SEGMENT = '0;
  logic [7:0]           TRANSITION_MODE = '0;
  logic [63:0]          TRANSITION_VALUE = '0;
  logic [NSEG*IW-1:0]   CYCLE = '0;
  logic [NSEG*RW-1:0]   REP = '0;
  logic                 IDX_TICK = 1'b0;
  logic [TW-1:0]        SYS_TIME = '0;
  logic [NG-1:0]        GPIO_IN = '0;
  logic [1:0]           SEGMENT;
  logic [IW-1:0]        IDX;
  logic                 STOP;
  logic                 PENDING;

  segment_transition_ctl #(
    .NUM_SEGMENT(NSEG),
    .IDX_WIDTH  (IW),
    .REP_WIDTH  (RW),
    .NUM_GPIO   (NG),
    .TIME_WIDTH (TW)
  ) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .UPDATE_SETTINGS (UPDATE_SETTINGS),
    .REQ_SEGMENT     (REQ_SEGMENT),
    .TRANSITION_MODE (TRANSITION_MODE),
    .TRANSITION_VALUE(TRANSITION_VALUE),
    .CYCLE           (CYCLE),
    .REP             (REP),
    .IDX_TICK        (IDX_TICK),
    .SYS_TIME        (SYS_TIME),
    .GPIO_IN         (GPIO_IN),
    .SEGMENT         (SEGMENT),
    .IDX             (IDX),
    .STOP            (STOP),
    .PENDING         (PENDING)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, upd, tick;
    logic [1:0]  req;
    logic [7:0]  mode;
    logic [63:0] val;
    logic [15:0] rep0;
    logic [55:0] stime;
    logic [3:0]  gpio;
    logic [1:0]  seg;
    logic [14:0] idx;
    logic        stop, pend;
  } vec_t;

  typedef struct {
    logic [1:0]  seg;
    logic [14:0] idx;
    logic        stop, pend;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // seg0=3, seg1=5, seg2=2, seg3=1
  localparam logic [NSEG*IW-1:0] CYCLE_MAIN = {15'd1, 15'd2, 15'd5, 15'd3};

  function automatic vec_t mk(input int rst, input int upd, input int tick, input int req,
                              input int mode, input logic [63:0] val, input int rep0,
                              input logic [55:0] stime, input int gpio,
                              input int seg, input int idx, input int stop, input int pend);
    vec_t v;
    v.rst = 1'(rst); v.upd = 1'(upd); v.tick = 1'(tick);
    v.req = 2'(req); v.mode = 8'(mode); v.val = val; v.rep0 = 16'(rep0);
    v.stime = stime; v.gpio = 4'(gpio);
    v.seg = 2'(seg); v.idx = 15'(idx); v.stop = 1'(stop); v.pend = 1'(pend);
    return v;
  endfunction

  function automatic vec_t rs();
    return mk(1, 0, 0, 0, 0, 64'd0, 65535, 56'd0, 0, 0, 0, 0, 0);
  endfunction
  function automatic vec_t up(input int req, input int mode, input logic [63:0] val, input int rep0,
                              input int seg, input int idx, input int pend);
    return mk(0, 1, 0, req, mode, val, rep0, 56'd0, 0, seg, idx, 0, pend);
  endfunction
  function automatic vec_t tk(input logic [55:0] stime, input int seg, input int idx,
                              input int stop, input int pend);
    return mk(0, 0, 1, 0, 0, 64'd0, 65535, stime, 0, seg, idx, stop, pend);
  endfunction
  function automatic vec_t gp(input int gpio, input int seg, input int idx, input int pend);
    return mk(0, 0, 0, 0, 0, 64'd0, 65535, 56'd0, gpio, seg, idx, 0, pend);
  endfunction

  task automatic check(input string name);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, nothing to compare", name);
      return;
    end
    e = sb.pop_front();
    if ({SEGMENT, IDX, STOP, PENDING} !== {e.seg, e.idx, e.stop, e.pend}) begin
      n_fail++;
      $display("FAIL %s: got seg=%0d idx=%0d stop=%0b pend=%0b, expected seg=%0d idx=%0d stop=%0b pend=%0b",
               name, SEGMENT, IDX, STOP, PENDING, e.seg, e.idx, e.stop, e.pend);
    end
  endtask

  task automatic push_exp(input int seg, input int idx, input int stop, input int pend);
    exp_t e;
    e.seg = 2'(seg); e.idx = 15'(idx); e.stop = 1'(stop); e.pend = 1'(pend);
    sb.push_back(e);
  endtask

  initial begin
    // 1: free-running loop, infinite repeat
    vecs.push_back(rs());
    vecs.push_back(up(0, 8'h00, 64'd0, 65535, 0, 0, 0));
    for (int k = 1; k <= 10; k++) vecs.push_back(tk(56'd0, 0, k % 4, 0, 0));
    // 2: REP0=1 -> two loops then frozen at CYCLE
    vecs.push_back(rs());
    vecs.push_back(up(0, 8'h00, 64'd0, 1, 0, 0, 0));
    for (int k = 1; k <= 10; k++)
      vecs.push_back(tk(56'd0, 0, (k <= 7) ? k % 4 : 3, (k >= 8) ? 1 : 0, 0));
    // 3: SYNC_IDX switch at end of cycle
    vecs.push_back(rs());
    vecs.push_back(up(0, 8'h00, 64'd0, 65535, 0, 0, 0));
    vecs.push_back(tk(56'd0, 0, 1, 0, 0));
    vecs.push_back(up(1, 8'h00, 64'd0, 65535, 0, 1, 1));
    vecs.push_back(tk(56'd0, 0, 2, 0, 1));
    vecs.push_back(tk(56'd0, 0, 3, 0, 1));
    vecs.push_back(tk(56'd0, 1, 0, 0, 0));
    vecs.push_back(tk(56'd0, 1, 1, 0, 0));
    // 4: SYS_TIME threshold and past time
    vecs.push_back(rs());
    vecs.push_back(up(0, 8'h00, 64'd0, 65535, 0, 0, 0));
    vecs.push_back(up(1, 8'h01, 64'd1000, 65535, 0, 0, 1));
    vecs.push_back(tk(56'd999, 0, 1, 0, 1));
    vecs.push_back(tk(56'd1000, 1, 0, 0, 0));
    vecs.push_back(up(0, 8'h01, 64'd5, 65535, 1, 0, 1));
    vecs.push_back(tk(56'd1000, 0, 0, 0, 0));
    // 5: GPIO pin 2; a pulse on pin 1 is ignored
    vecs.push_back(rs());
    vecs.push_back(up(0, 8'h00, 64'd0, 65535, 0, 0, 0));
    vecs.push_back(up(1, 8'h02, 64'd2, 65535, 0, 0, 1));
    for (int k = 0; k < 3; k++) vecs.push_back(gp(4'b0010, 0, 0, 1));
    for (int k = 0; k < 3; k++) vecs.push_back(gp(4'b0000, 0, 0, 1));
    vecs.push_back(tk(56'd0, 0, 1, 0, 1));
    for (int k = 0; k < 3; k++) vecs.push_back(gp(4'b0100, 0, 1, 1));
    for (int k = 0; k < 3; k++) vecs.push_back(gp(4'b0000, 0, 1, 1));
    vecs.push_back(tk(56'd0, 1, 0, 0, 0));
    // Replacement: unreachable time request replaced by an unknown code (acts as SYNC_IDX)
    vecs.push_back(up(0, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF, 65535, 1, 0, 1));
    vecs.push_back(up(0, 8'h55, 64'd0, 65535, 1, 0, 1));
    for (int k = 1; k <= 5; k++) vecs.push_back(tk(56'd0, 1, k, 0, 1));
    vecs.push_back(tk(56'd0, 0, 0, 0, 0));
    // Update and tick together: tick advances under old settings, request arms afterwards
    vecs.push_back(mk(0, 1, 1, 1, 8'h00, 64'd0, 65535, 56'd0, 0, 0, 1, 0, 1));
    vecs.push_back(tk(56'd0, 0, 2, 0, 1));
    vecs.push_back(tk(56'd0, 0, 3, 0, 1));
    vecs.push_back(tk(56'd0, 1, 0, 0, 0));

    CYCLE = CYCLE_MAIN;
    foreach (vecs[i]) begin
      @(negedge CLK);
      if (vecs[i].rst) begin
        UPDATE_SETTINGS = 1'b0;
        IDX_TICK = 1'b0;
        GPIO_IN = '0;
        RST_N = 1'b0;
        push_exp(0, 0, 0, 0);
        #2;
        check($sformatf("vec%0d_reset", i));
        RST_N = 1'b1;
      end else begin
        UPDATE_SETTINGS  = vecs[i].upd;
        IDX_TICK         = vecs[i].tick;
        REQ_SEGMENT      = vecs[i].req;
        TRANSITION_MODE  = vecs[i].mode;
        TRANSITION_VALUE = vecs[i].val;
        REP              = {16'hFFFF, 16'hFFFF, 16'hFFFF, vecs[i].rep0};
        SYS_TIME         = vecs[i].stime;
        GPIO_IN          = vecs[i].gpio;
        sb.push_back('{vecs[i].seg, vecs[i].idx, vecs[i].stop, vecs[i].pend});
        @(posedge CLK);
        #1;
        check($sformatf("vec%0d", i));
        UPDATE_SETTINGS = 1'b0;
        IDX_TICK = 1'b0;
      end
    end

    // 6: EXT auto-advance across four segments, then async reset with a request armed
    @(negedge CLK);
    RST_N = 1'b0;
    GPIO_IN = '0;
    push_exp(0, 0, 0, 0);
    #2;
    check("ext_reset");
    RST_N = 1'b1;
    @(negedge CLK);
    CYCLE = {NSEG{15'd1}};
    REP = '0;
    REQ_SEGMENT = 2'd0;
    TRANSITION_MODE = 8'hF0;
    UPDATE_SETTINGS = 1'b1;
    push_exp(0, 0, 0, 0);
    @(posedge CLK);
    #1;
    check("ext_arm");
    UPDATE_SETTINGS = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge CLK);
      IDX_TICK = 1'b1;
      push_exp((k / 2) % 4, k % 2, 0, 0);
      @(posedge CLK);
      #1;
      check($sformatf("ext_tick%0d", k));
      IDX_TICK = 1'b0;
    end
    @(negedge CLK);
    REQ_SEGMENT = 2'd3;
    TRANSITION_MODE = 8'h00;
    UPDATE_SETTINGS = 1'b1;
    push_exp(1, 1, 0, 1);
    @(posedge CLK);
    #1;
    check("ext_pending");
    UPDATE_SETTINGS = 1'b0;
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    push_exp(0, 0, 0, 0);
    #1;
    check("async_reset_midrun");
    @(negedge CLK);
    RST_N = 1'b1;
    // Settings were cleared by reset: zero-length, zero-repeat segment stops on the first tick
    @(negedge CLK);
    IDX_TICK = 1'b1;
    push_exp(0, 0, 1, 0);
    @(posedge CLK);
    #1;
    check("post_reset_tick");
    IDX_TICK = 1'b0;

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
